// File: rtl/hello_nios2_qsys_oci_dct_monitor.sv
// Debug monitor for Nios II OCI direct-control-transfer trace words: buffers
// accepted words in a FIFO for a reader, keeps error flags and a code total, and tracks end of test.
module hello_nios2_qsys_oci_dct_monitor #(
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int STAT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dct_valid,
    input  logic [BUF_W-1:0]          dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [CNT_W+BUF_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic [STAT_W-1:0]         code_total,
    output logic                      overflow,
    output logic                      count_err,
    output logic                      drained,
    output logic                      done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int EW    = CNT_W + BUF_W;
    localparam int SUM_W = ((STAT_W > CNT_W) ? STAT_W : CNT_W) + 1;

    localparam logic [CNT_W-1:0]  MAXC_C  = CNT_W'(BUF_W / 2);
    localparam logic [LW-1:0]     FULL_C  = LW'(DEPTH);
    localparam logic [STAT_W-1:0] TOT_MAX = {STAT_W{1'b1}};

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [STAT_W-1:0] total_q, total_d;
    logic [EW-1:0]     head_q, head_d;
    logic              rd_valid_q;
    logic              overflow_q, overflow_d;
    logic              count_err_q, count_err_d;
    logic              drained_q;
    logic              done_q;
    logic [EW-1:0]     mem_q [DEPTH];

    logic              push_try_s;
    logic              cnt_bad_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic [EW-1:0]     entry_s;
    logic [SUM_W-1:0]  sum_s;

    // Next-state logic: push/pop arbitration, pointers, flags, total and end-of-test sequencing.
    always_comb begin
        push_try_s  = dct_valid && (state_q == ST_RUN);
        cnt_bad_s   = (dct_count > MAXC_C);
        full_s      = (level_q == FULL_C);
        pop_s       = rd_valid_q && rd_ready;
        push_s      = push_try_s && !cnt_bad_s && (!full_s || pop_s);
        entry_s     = {dct_count, dct_buffer};
        sum_s       = SUM_W'(total_q) + SUM_W'(dct_count);

        wr_ptr_d    = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        if (push_s && !pop_s) begin
            level_d = level_q + LW'(1);
        end else if (pop_s && !push_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end

        if (!push_s) begin
            total_d = total_q;
        end else if (sum_s > SUM_W'(TOT_MAX)) begin
            total_d = TOT_MAX;
        end else begin
            total_d = sum_s[STAT_W-1:0];
        end

        // count_err takes precedence, so an oversized word in a full FIFO is never reported as overflow
        count_err_d = count_err_q || (push_try_s && cnt_bad_s);
        overflow_d  = overflow_q || (push_try_s && !cnt_bad_s && full_s && !pop_s);

        if (level_d == LW'(0)) begin
            head_d = '0;
        end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_d = entry_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        case (state_q)
            ST_RUN: begin
                if (test_has_ended) begin
                    state_d = ST_DONE;
                end else if (test_ending) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (test_has_ended) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            total_q     <= '0;
            head_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            count_err_q <= 1'b0;
            drained_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            total_q     <= total_d;
            head_q      <= head_d;
            rd_valid_q  <= (level_d != LW'(0));
            overflow_q  <= overflow_d;
            count_err_q <= count_err_d;
            drained_q   <= (state_q != ST_RUN) && (level_q == LW'(0));
            done_q      <= (state_d == ST_DONE);
        end
    end

    // Entry storage; contents are meaningless while level is 0, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = head_q;
    assign level      = level_q;
    assign code_total = total_q;
    assign overflow   = overflow_q;
    assign count_err  = count_err_q;
    assign drained    = drained_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hello_nios2_qsys_oci_dct_monitor.sv
// Directed bench: instance A uses default parameters, instance B uses BUF_W=20, STAT_W=4
// for the count-range and total-saturation corners.
module tb_hello_nios2_qsys_oci_dct_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Instance A (defaults: BUF_W=30, CNT_W=4, DEPTH=16, STAT_W=16)
    logic        a_rst_n, a_valid, a_ending, a_ended, a_ready;
    logic [29:0] a_buf;
    logic [3:0]  a_cnt;
    logic        a_rd_valid, a_ovf, a_cerr, a_drained, a_done;
    logic [33:0] a_rd_data;
    logic [4:0]  a_level;
    logic [15:0] a_total;

    // Instance B (BUF_W=20 -> MAXC=10, STAT_W=4)
    logic        b_rst_n, b_valid, b_ending, b_ended, b_ready;
    logic [19:0] b_buf;
    logic [3:0]  b_cnt;
    logic        b_rd_valid, b_ovf, b_cerr, b_drained, b_done;
    logic [23:0] b_rd_data;
    logic [4:0]  b_level;
    logic [3:0]  b_total;

    logic [29:0] w0, w1, w2;

    hello_nios2_qsys_oci_dct_monitor dut_a (
        .clk(clk), .reset_n(a_rst_n), .dct_valid(a_valid), .dct_buffer(a_buf),
        .dct_count(a_cnt), .test_ending(a_ending), .test_has_ended(a_ended),
        .rd_ready(a_ready), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .level(a_level), .code_total(a_total), .overflow(a_ovf),
        .count_err(a_cerr), .drained(a_drained), .done(a_done)
    );

    hello_nios2_qsys_oci_dct_monitor #(.BUF_W(20), .CNT_W(4), .DEPTH(16), .STAT_W(4)) dut_b (
        .clk(clk), .reset_n(b_rst_n), .dct_valid(b_valid), .dct_buffer(b_buf),
        .dct_count(b_cnt), .test_ending(b_ending), .test_has_ended(b_ended),
        .rd_ready(b_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .level(b_level), .code_total(b_total), .overflow(b_ovf),
        .count_err(b_cerr), .drained(b_drained), .done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        w0 = 30'h0123_4567;
        w1 = 30'h2345_6789;
        w2 = 30'h3fff_0000;
        a_rst_n = 1'b0; a_valid = 1'b1; a_buf = w0; a_cnt = 4'd3;
        a_ending = 1'b0; a_ended = 1'b0; a_ready = 1'b0;
        b_rst_n = 1'b0; b_valid = 1'b1; b_buf = 20'h0; b_cnt = 4'd2;
        b_ending = 1'b0; b_ended = 1'b0; b_ready = 1'b0;

        // 1: reset held two clocks with dct_valid high
        tick(); tick();
        chk("rst_rd_valid",  64'(a_rd_valid), 64'd0);
        chk("rst_rd_data",   64'(a_rd_data),  64'd0);
        chk("rst_level",     64'(a_level),    64'd0);
        chk("rst_total",     64'(a_total),    64'd0);
        chk("rst_overflow",  64'(a_ovf),      64'd0);
        chk("rst_count_err", 64'(a_cerr),     64'd0);
        chk("rst_drained",   64'(a_drained),  64'd0);
        chk("rst_done",      64'(a_done),     64'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        chk("rel_done",  64'(a_done),  64'd0);
        chk("rel_level", 64'(a_level), 64'd0);

        // 2: three pushes held, then read out in order
        a_valid = 1'b1; a_cnt = 4'd1; a_buf = w0;
        tick();
        chk("p1_rd_valid", 64'(a_rd_valid), 64'd1);
        chk("p1_head",     64'(a_rd_data),  64'({4'd1, w0}));
        a_cnt = 4'd5; a_buf = w1;
        tick();
        a_cnt = 4'd15; a_buf = w2;
        tick();
        a_valid = 1'b0;
        chk("p3_level", 64'(a_level),   64'd3);
        chk("p3_total", 64'(a_total),   64'd21);
        chk("p3_head",  64'(a_rd_data), 64'({4'd1, w0}));
        a_ready = 1'b1;
        tick();
        chk("rd_head1", 64'(a_rd_data), 64'({4'd5, w1}));
        tick();
        chk("rd_head2", 64'(a_rd_data), 64'({4'd15, w2}));
        tick();
        chk("rd_empty_level", 64'(a_level),    64'd0);
        chk("rd_empty_valid", 64'(a_rd_valid), 64'd0);
        chk("rd_empty_data",  64'(a_rd_data),  64'd0);
        chk("run_drained",    64'(a_drained),  64'd0);
        a_ready = 1'b0;

        // 3: fill to 16, drop the 17th, then push+pop while full
        a_valid = 1'b1; a_cnt = 4'd1;
        for (int i = 0; i < 16; i++) begin
            a_buf = 30'(i);
            tick();
        end
        chk("fill_level",    64'(a_level), 64'd16);
        chk("fill_overflow", 64'(a_ovf),   64'd0);
        chk("fill_total",    64'(a_total), 64'd37);
        a_cnt = 4'd2; a_buf = 30'h3abc;
        tick();
        chk("ovf_flag",  64'(a_ovf),   64'd1);
        chk("ovf_level", 64'(a_level), 64'd16);
        chk("ovf_total", 64'(a_total), 64'd37);
        chk("ovf_cerr",  64'(a_cerr),  64'd0);
        a_cnt = 4'd3; a_ready = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("full_pp_level", 64'(a_level),   64'd16);
        chk("full_pp_total", 64'(a_total),   64'd40);
        chk("full_pp_head",  64'(a_rd_data), 64'({4'd1, 30'd1}));
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("tail_head", 64'(a_rd_data), 64'({4'd3, 30'h3abc}));
        tick();
        chk("drain_all_level", 64'(a_level), 64'd0);
        a_ready = 1'b0;

        // 5: push in the test_ending cycle, later pushes ignored, drain, then DONE
        a_valid = 1'b1; a_cnt = 4'd4; a_buf = w1; a_ending = 1'b1;
        tick();
        a_ending = 1'b0;
        chk("end_push_level", 64'(a_level), 64'd1);
        chk("end_push_total", 64'(a_total), 64'd44);
        a_cnt = 4'd2;
        tick();
        a_valid = 1'b0;
        chk("drain_nopush_level", 64'(a_level), 64'd1);
        chk("drain_nopush_total", 64'(a_total), 64'd44);
        chk("drain_busy",         64'(a_drained), 64'd0);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        chk("drain_pop_level", 64'(a_level), 64'd0);
        tick();
        chk("drained_set", 64'(a_drained), 64'd1);
        chk("drain_done",  64'(a_done),    64'd0);
        a_ended = 1'b1;
        tick();
        a_ended = 1'b0;
        chk("done_set", 64'(a_done), 64'd1);
        a_valid = 1'b1; a_ending = 1'b1;
        tick();
        a_valid = 1'b0; a_ending = 1'b0;
        chk("done_sticky",  64'(a_done),    64'd1);
        chk("done_nopush",  64'(a_level),   64'd0);
        chk("done_drained", 64'(a_drained), 64'd1);

        // 4: count range on B (MAXC=10)
        b_valid = 1'b1; b_cnt = 4'd11; b_buf = 20'habcde;
        tick();
        chk("b_cerr_flag",  64'(b_cerr),  64'd1);
        chk("b_cerr_level", 64'(b_level), 64'd0);
        chk("b_cerr_total", 64'(b_total), 64'd0);
        b_cnt = 4'd10;
        tick();
        chk("b_max_level", 64'(b_level),   64'd1);
        chk("b_max_total", 64'(b_total),   64'd10);
        chk("b_max_head",  64'(b_rd_data), 64'({4'd10, 20'habcde}));
        chk("b_max_ovf",   64'(b_ovf),     64'd0);

        // 6: saturation at 2**4-1, then reset mid-DRAIN
        b_buf = 20'h12345;
        tick();
        chk("b_sat_total", 64'(b_total), 64'd15);
        b_cnt = 4'd5;
        tick();
        chk("b_sat_hold",  64'(b_total), 64'd15);
        chk("b_sat_level", 64'(b_level), 64'd3);
        b_valid = 1'b0; b_ending = 1'b1;
        tick();
        b_ending = 1'b0;
        b_valid = 1'b1; b_cnt = 4'd1;
        tick();
        b_valid = 1'b0;
        chk("b_drain_nopush", 64'(b_level), 64'd3);
        b_rst_n = 1'b0;
        tick();
        chk("b_rst_level", 64'(b_level),    64'd0);
        chk("b_rst_total", 64'(b_total),    64'd0);
        chk("b_rst_cerr",  64'(b_cerr),     64'd0);
        chk("b_rst_valid", 64'(b_rd_valid), 64'd0);
        chk("b_rst_data",  64'(b_rd_data),  64'd0);
        b_rst_n = 1'b1;
        b_valid = 1'b1; b_cnt = 4'd1; b_buf = 20'h00f0f;
        tick();
        b_valid = 1'b0;
        chk("b_run_again_level", 64'(b_level),   64'd1);
        chk("b_run_again_head",  64'(b_rd_data), 64'({4'd1, 20'h00f0f}));
        chk("b_run_again_done",  64'(b_done),    64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
